// File: rtl/srv_icb_pkg.sv
// Shared ICB constants and index helpers for the srv_icb_splt command splitter.
package srv_icb_pkg;

    localparam int W_ADDR    = 32;
    localparam int W_DATA    = 32;
    localparam int W_MASK    = W_DATA / 8;
    localparam int N_SLV     = 2;
    localparam int DFLT_IDX  = N_SLV;
    localparam int ERR_CNT_W = 16;

    function automatic int mask_w(input int w_data);
        return w_data / 8;
    endfunction

    // One extra code point is reserved for the default-slave port.
    function automatic int tgt_w(input int n_slv);
        return $clog2(n_slv + 1);
    endfunction

    function automatic int dflt_idx(input int n_slv);
        return n_slv;
    endfunction

endpackage

// File: rtl/srv_icb_splt_fifo.sv
// In-order FIFO of target port indices, one entry per outstanding ICB transaction.
module srv_icb_splt_fifo #(
    parameter int G_OUTS_DEPTH = 2,
    parameter int G_W          = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic [G_W-1:0] din,
    input  logic           pop,
    output logic [G_W-1:0] dout,
    output logic           full,
    output logic           empty
);
    localparam int PW = (G_OUTS_DEPTH > 1) ? $clog2(G_OUTS_DEPTH) : 1;
    localparam int CW = $clog2(G_OUTS_DEPTH + 1);

    logic [G_W-1:0] mem [G_OUTS_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(G_OUTS_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(G_OUTS_DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Entry storage carries no reset; stale entries are never read while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/srv_icb_splt.sv
// 1-to-N ICB command splitter with default-slave port and in-order response return.
// Optional SRV_ICB_SPLT_ERR_CNT_EN adds a saturating count of default-port commands.
module srv_icb_splt
    import srv_icb_pkg::*;
#(
    parameter int                          G_W_ADDR     = 32,
    parameter int                          G_W_DATA     = 32,
    parameter int                          G_N_SLV      = 2,
    parameter logic [G_N_SLV*G_W_ADDR-1:0] G_SLV_BASE   = {32'h2000_0000, 32'h1000_0000},
    parameter logic [G_N_SLV*G_W_ADDR-1:0] G_SLV_MASK   = {32'hF000_0000, 32'hF000_0000},
    parameter int                          G_OUTS_DEPTH = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
`ifdef SRV_ICB_SPLT_ERR_CNT_EN
    output logic [15:0]                           err_cnt,
`endif
    input  logic                                  mst_cmd_valid,
    output logic                                  mst_cmd_ready,
    input  logic [G_W_ADDR-1:0]                   mst_cmd_addr,
    input  logic                                  mst_cmd_read,
    input  logic [G_W_DATA-1:0]                   mst_cmd_wdata,
    input  logic [mask_w(G_W_DATA)-1:0]           mst_cmd_wmask,
    output logic                                  mst_resp_valid,
    input  logic                                  mst_resp_ready,
    output logic [G_W_DATA-1:0]                   mst_resp_rdata,
    output logic                                  mst_resp_err,
    output logic [G_N_SLV-1:0]                    slv_cmd_valid,
    input  logic [G_N_SLV-1:0]                    slv_cmd_ready,
    output logic [G_N_SLV*G_W_ADDR-1:0]           slv_cmd_addr,
    output logic [G_N_SLV-1:0]                    slv_cmd_read,
    output logic [G_N_SLV*G_W_DATA-1:0]           slv_cmd_wdata,
    output logic [G_N_SLV*mask_w(G_W_DATA)-1:0]   slv_cmd_wmask,
    input  logic [G_N_SLV-1:0]                    slv_resp_valid,
    output logic [G_N_SLV-1:0]                    slv_resp_ready,
    input  logic [G_N_SLV*G_W_DATA-1:0]           slv_resp_rdata,
    input  logic [G_N_SLV-1:0]                    slv_resp_err,
    output logic                                  dslv_cmd_valid,
    input  logic                                  dslv_cmd_ready,
    output logic [G_W_ADDR-1:0]                   dslv_cmd_addr,
    output logic                                  dslv_cmd_read,
    output logic [G_W_DATA-1:0]                   dslv_cmd_wdata,
    output logic [mask_w(G_W_DATA)-1:0]           dslv_cmd_wmask,
    input  logic                                  dslv_resp_valid,
    output logic                                  dslv_resp_ready,
    input  logic [G_W_DATA-1:0]                   dslv_resp_rdata,
    input  logic                                  dslv_resp_err
);
    localparam int TW = tgt_w(G_N_SLV);
    localparam int DI = dflt_idx(G_N_SLV);

    // Handshake: a transfer occurs on a clock edge where valid and ready are both high;
    // valid never waits on ready, and each port sees only its own valid/ready pair.

    logic [TW-1:0] tgt;
    logic [TW-1:0] head;
    logic          tgt_ready;
    logic          head_valid;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Scan from the top so the lowest matching index is the one left in tgt.
    always_comb begin
        tgt = TW'(DI);
        for (int i = G_N_SLV - 1; i >= 0; i--) begin
            if ((mst_cmd_addr & G_SLV_MASK[i*G_W_ADDR +: G_W_ADDR]) ==
                (G_SLV_BASE[i*G_W_ADDR +: G_W_ADDR] & G_SLV_MASK[i*G_W_ADDR +: G_W_ADDR]))
                tgt = TW'(i);
        end
    end

    always_comb begin
        slv_cmd_valid  = '0;
        dslv_cmd_valid = 1'b0;
        tgt_ready      = dslv_cmd_ready;
        if (tgt == TW'(DI)) dslv_cmd_valid = mst_cmd_valid & ~full;
        for (int i = 0; i < G_N_SLV; i++) begin
            if (tgt == TW'(i)) begin
                slv_cmd_valid[i] = mst_cmd_valid & ~full;
                tgt_ready        = slv_cmd_ready[i];
            end
        end
    end

    assign mst_cmd_ready  = tgt_ready & ~full;
    assign push           = mst_cmd_valid & mst_cmd_ready;

    assign slv_cmd_addr   = {G_N_SLV{mst_cmd_addr}};
    assign slv_cmd_read   = {G_N_SLV{mst_cmd_read}};
    assign slv_cmd_wdata  = {G_N_SLV{mst_cmd_wdata}};
    assign slv_cmd_wmask  = {G_N_SLV{mst_cmd_wmask}};
    assign dslv_cmd_addr  = mst_cmd_addr;
    assign dslv_cmd_read  = mst_cmd_read;
    assign dslv_cmd_wdata = mst_cmd_wdata;
    assign dslv_cmd_wmask = mst_cmd_wmask;

    always_comb begin
        head_valid      = dslv_resp_valid;
        mst_resp_rdata  = dslv_resp_rdata;
        mst_resp_err    = dslv_resp_err;
        slv_resp_ready  = '0;
        dslv_resp_ready = ~empty & (head == TW'(DI)) & mst_resp_ready;
        for (int i = 0; i < G_N_SLV; i++) begin
            if (head == TW'(i)) begin
                head_valid        = slv_resp_valid[i];
                mst_resp_rdata    = slv_resp_rdata[i*G_W_DATA +: G_W_DATA];
                mst_resp_err      = slv_resp_err[i];
                slv_resp_ready[i] = ~empty & mst_resp_ready;
            end
        end
    end

    assign mst_resp_valid = ~empty & head_valid;
    assign pop            = mst_resp_valid & mst_resp_ready;

    srv_icb_splt_fifo #(
        .G_OUTS_DEPTH (G_OUTS_DEPTH),
        .G_W          (TW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (tgt),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

`ifdef SRV_ICB_SPLT_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            err_cnt <= '0;
        else if (push && (tgt == TW'(DI)) && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
    end
`else
    // Default build carries no error counter.
`endif

endmodule

// File: tb/tb_srv_icb_splt.sv
// Scoreboard bench for srv_icb_splt: three decoded slaves (slave2 overlaps slave0) plus default port.
module tb_srv_icb_splt;
    localparam int N = 3;
    localparam int P = N + 1;
    localparam int D = 2;

    logic            clk;
    logic            reset;
`ifdef SRV_ICB_SPLT_ERR_CNT_EN
    logic [15:0]     err_cnt;
`endif
    logic            mst_cmd_valid, mst_cmd_ready, mst_cmd_read;
    logic [31:0]     mst_cmd_addr, mst_cmd_wdata;
    logic [3:0]      mst_cmd_wmask;
    logic            mst_resp_valid, mst_resp_ready, mst_resp_err;
    logic [31:0]     mst_resp_rdata;
    logic [N-1:0]    slv_cmd_valid, slv_cmd_ready, slv_cmd_read;
    logic [N*32-1:0] slv_cmd_addr, slv_cmd_wdata;
    logic [N*4-1:0]  slv_cmd_wmask;
    logic [N-1:0]    slv_resp_valid, slv_resp_ready, slv_resp_err;
    logic [N*32-1:0] slv_resp_rdata;
    logic            dslv_cmd_valid, dslv_cmd_ready, dslv_cmd_read;
    logic [31:0]     dslv_cmd_addr, dslv_cmd_wdata;
    logic [3:0]      dslv_cmd_wmask;
    logic            dslv_resp_valid, dslv_resp_ready, dslv_resp_err;
    logic [31:0]     dslv_resp_rdata;

    srv_icb_splt #(
        .G_W_ADDR     (32),
        .G_W_DATA     (32),
        .G_N_SLV      (N),
        .G_SLV_BASE   ({32'h1000_0000, 32'h2000_0000, 32'h1000_0000}),
        .G_SLV_MASK   ({32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000}),
        .G_OUTS_DEPTH (D)
    ) dut (
        .clk             (clk),
        .reset           (reset),
`ifdef SRV_ICB_SPLT_ERR_CNT_EN
        .err_cnt         (err_cnt),
`endif
        .mst_cmd_valid   (mst_cmd_valid),
        .mst_cmd_ready   (mst_cmd_ready),
        .mst_cmd_addr    (mst_cmd_addr),
        .mst_cmd_read    (mst_cmd_read),
        .mst_cmd_wdata   (mst_cmd_wdata),
        .mst_cmd_wmask   (mst_cmd_wmask),
        .mst_resp_valid  (mst_resp_valid),
        .mst_resp_ready  (mst_resp_ready),
        .mst_resp_rdata  (mst_resp_rdata),
        .mst_resp_err    (mst_resp_err),
        .slv_cmd_valid   (slv_cmd_valid),
        .slv_cmd_ready   (slv_cmd_ready),
        .slv_cmd_addr    (slv_cmd_addr),
        .slv_cmd_read    (slv_cmd_read),
        .slv_cmd_wdata   (slv_cmd_wdata),
        .slv_cmd_wmask   (slv_cmd_wmask),
        .slv_resp_valid  (slv_resp_valid),
        .slv_resp_ready  (slv_resp_ready),
        .slv_resp_rdata  (slv_resp_rdata),
        .slv_resp_err    (slv_resp_err),
        .dslv_cmd_valid  (dslv_cmd_valid),
        .dslv_cmd_ready  (dslv_cmd_ready),
        .dslv_cmd_addr   (dslv_cmd_addr),
        .dslv_cmd_read   (dslv_cmd_read),
        .dslv_cmd_wdata  (dslv_cmd_wdata),
        .dslv_cmd_wmask  (dslv_cmd_wmask),
        .dslv_resp_valid (dslv_resp_valid),
        .dslv_resp_ready (dslv_resp_ready),
        .dslv_resp_rdata (dslv_resp_rdata),
        .dslv_resp_err   (dslv_resp_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int          tests_run = 0;
    int          tests_failed = 0;
    int          dflt_hs = 0;
    logic [32:0] exp_q [$];      // {err, rdata} expected at the master, in command order
    int          tq [$];         // expected target of each outstanding transaction
    logic [32:0] mq [$];         // master commands still to issue: {read, addr}
    logic [32:0] sq [P][$];      // per-slave pending responses
    logic [P-1:0] rdy, ren, rv;
    logic        mrr;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] key(input int p);
        return 32'(32'h1111_1111 * (p + 1));
    endfunction

    // Reference decode: first window in index order that contains the address.
    function automatic int model_tgt(input logic [31:0] a);
        logic [31:0] base [N];
        logic [31:0] msk  [N];
        base[0] = 32'h1000_0000; msk[0] = 32'hF000_0000;
        base[1] = 32'h2000_0000; msk[1] = 32'hF000_0000;
        base[2] = 32'h1000_0000; msk[2] = 32'hFFFF_0000;
        for (int i = 0; i < N; i++)
            if ((a & msk[i]) == base[i]) return i;
        return N;
    endfunction

    // What the slave on port p returns for the command it currently sees.
    function automatic logic [32:0] slave_resp(input int p);
        logic [31:0] a, wd;
        logic [3:0]  wm;
        logic        rd;
        if (p < N) begin
            a = slv_cmd_addr[p*32 +: 32]; wd = slv_cmd_wdata[p*32 +: 32];
            wm = slv_cmd_wmask[p*4 +: 4]; rd = slv_cmd_read[p];
        end else begin
            a = dslv_cmd_addr; wd = dslv_cmd_wdata; wm = dslv_cmd_wmask; rd = dslv_cmd_read;
        end
        return {p == P - 1, a ^ key(p) ^ (rd ? 32'h0 : wd) ^ {28'h0, wm}};
    endfunction

    function automatic logic [32:0] exp_resp(input int t, input logic [32:0] c);
        logic [31:0] a;
        a = c[31:0];
        return {t == P - 1, a ^ key(t) ^ (c[32] ? 32'h0 : ~a) ^ {28'h0, a[3:0]}};
    endfunction

    task automatic observe();
        int          t, hd;
        logic [P-1:0] cv, cr, rr, exp_cv, exp_rr;
        logic [32:0] e;
        logic        full_m;
        t      = model_tgt(mst_cmd_addr);
        full_m = (tq.size() >= D);
        cv = {dslv_cmd_valid, slv_cmd_valid};
        cr = {dslv_cmd_ready, slv_cmd_ready};
        rr = {dslv_resp_ready, slv_resp_ready};
        exp_cv = '0;
        if (mst_cmd_valid && !full_m) exp_cv[t] = 1'b1;
        hd = (tq.size() > 0) ? tq[0] : -1;
        exp_rr = '0;
        if (hd >= 0 && mst_resp_ready) exp_rr[hd] = 1'b1;
        check("cmd_valid", cv, exp_cv);
        check("cmd_ready", mst_cmd_ready, rdy[t] && !full_m);
        check("resp_ready", rr, exp_rr);
        check("resp_valid", mst_resp_valid, (hd >= 0) ? rv[hd] : 1'b0);
        check("occupancy", dut.u_fifo.count, tq.size());
        for (int p = 0; p < P; p++)
            if (rv[p] && rr[p]) void'(sq[p].pop_front());
        if (mst_resp_valid && mst_resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", mst_resp_rdata, e[31:0]);
                check("resp_err", mst_resp_err, e[32]);
            end
            if (tq.size() > 0) void'(tq.pop_front());
        end
        for (int p = 0; p < P; p++)
            if (cv[p] && cr[p]) sq[p].push_back(slave_resp(p));
        if (mst_cmd_valid && mst_cmd_ready) begin
            exp_q.push_back(exp_resp(t, mq[0]));
            tq.push_back(t);
            if (t == P - 1) dflt_hs++;
            void'(mq.pop_front());
        end
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(negedge clk);
        mst_cmd_valid = !reset && (mq.size() > 0);
        if (mq.size() > 0) begin
            mst_cmd_read  = mq[0][32];
            mst_cmd_addr  = mq[0][31:0];
            mst_cmd_wdata = ~mq[0][31:0];
            mst_cmd_wmask = mq[0][3:0];
        end
        {dslv_cmd_ready, slv_cmd_ready} = rdy;
        mst_resp_ready = mrr;
        for (int p = 0; p < P; p++) begin
            logic [32:0] r;
            rv[p] = ren[p] && (sq[p].size() > 0);
            r = rv[p] ? sq[p][0] : {1'b0, 32'($urandom)};
            if (p < N) begin
                slv_resp_valid[p] = rv[p];
                slv_resp_rdata[p*32 +: 32] = r[31:0];
                slv_resp_err[p] = r[32];
            end else begin
                dslv_resp_valid = rv[p];
                dslv_resp_rdata = r[31:0];
                dslv_resp_err   = r[32];
            end
        end
        #1;
        if (!reset) observe();
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((mq.size() > 0 || tq.size() > 0) && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_idle", mq.size() + tq.size(), 0);
    endtask

    task automatic rand_drain(input int max_cyc);
        int n = 0;
        while ((mq.size() > 0 || tq.size() > 0) && n < max_cyc) begin
            rdy = P'($urandom_range(0, (1 << P) - 1));
            ren = P'($urandom_range(0, (1 << P) - 1));
            mrr = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        rdy = '1; ren = '1; mrr = 1'b1;
        drain(40);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        rdy = '0; ren = '0; mrr = 1'b0; rv = '0;
        mst_cmd_valid = 1'b0; mst_cmd_read = 1'b0; mst_cmd_addr = '0;
        mst_cmd_wdata = '0; mst_cmd_wmask = '0; mst_resp_ready = 1'b0;
        slv_cmd_ready = '0; slv_resp_valid = '0; slv_resp_rdata = '0; slv_resp_err = '0;
        dslv_cmd_ready = 1'b0; dslv_resp_valid = 1'b0; dslv_resp_rdata = '0; dslv_resp_err = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_occupancy", dut.u_fifo.count, 0);
        check("rst_resp_valid", mst_resp_valid, 0);
        check("rst_cmd_valid", {dslv_cmd_valid, slv_cmd_valid}, 0);

        // single write to slave0
        rdy = '1; ren = '1; mrr = 1'b1;
        mq.push_back({1'b0, 32'h1000_0004});
        drain(20);

        // slave1 response held while slave0 already has its response ready
        ren = 4'b1101;
        mq.push_back({1'b1, 32'h2000_0010});
        mq.push_back({1'b1, 32'h1000_0000});
        repeat (8) step();
        check("hold_slv0_ready", slv_resp_ready[0], 0);
        check("hold_resp_valid", mst_resp_valid, 0);
        check("hold_slv0_pending", sq[0].size(), 1);
        ren = '1;
        drain(20);

        // unmapped address goes to the default slave, error response
        mq.push_back({1'b1, 32'h3000_0000});
        drain(20);

        // overlapping windows: slave2 also matches, slave0 must win
        mq.push_back({1'b1, 32'h1000_0000});
        mq.push_back({1'b0, 32'h1000_FFF8});
        drain(20);

        // depth limit: third command waits until a response retires
        mrr = 1'b0;
        mq.push_back({1'b1, 32'h1000_0100});
        mq.push_back({1'b1, 32'h2000_0200});
        mq.push_back({1'b1, 32'h3000_0300});
        repeat (5) step();
        check("full_cmd_ready", mst_cmd_ready, 0);
        check("full_cmd_valid", {dslv_cmd_valid, slv_cmd_valid}, 0);
        check("full_pending", mq.size(), 1);
        mrr = 1'b1;
        drain(30);

        // pointer wrap under random backpressure
        for (int i = 0; i < 14; i++) begin
            logic [31:0] a;
            a = $urandom;
            case ($urandom_range(0, 4))
                0: a = {4'h1, a[27:0]};
                1: a = {4'h2, a[27:0]};
                2: a = {4'h3, a[27:0]};
                3: a = {16'h1000, a[15:0]};
                default: a = {4'hC, a[27:0]};
            endcase
            mq.push_back({1'($urandom_range(0, 1)), a});
        end
        rand_drain(400);

        // reset with two outstanding transactions
        mrr = 1'b0;
        mq.push_back({1'b1, 32'h1000_0020});
        mq.push_back({1'b1, 32'h3000_0024});
        repeat (4) step();
        check("pre_rst_occupancy", dut.u_fifo.count, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        tq.delete();
        exp_q.delete();
        for (int p = 0; p < P; p++) sq[p].delete();
        mrr = 1'b1;
        rdy = 4'b1110;
        mq.push_back({1'b1, 32'h1000_0040});
        step();
        check("post_rst_occupancy", dut.u_fifo.count, 0);
        check("post_rst_resp_valid", mst_resp_valid, 0);
        check("post_rst_cmd_ready_lo", mst_cmd_ready, 0);
        rdy = '1;
        step();
        drain(20);

`ifdef SRV_ICB_SPLT_ERR_CNT_EN
        step();
        check("err_cnt", err_cnt, dflt_hs);
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/srv_icb_splt.md
Name: srv_icb_splt

Overview:
- 1-to-N ICB command splitter. Sits between a single ICB master (core LSU/bus port) and G_N_SLV ICB slaves plus one dedicated default-slave port.
- Commands whose address matches no slave window go to the default-slave port, which an error-responding default slave consumes.
- Tracks outstanding transactions in an in-order FIFO of target indices so responses return to the master in command order.

Parameters:
G_W_ADDR, 32, address width
G_W_DATA, 32, data width; wmask width is G_W_DATA/8
G_N_SLV, 2, number of decoded slave ports (>=1)
G_SLV_BASE, {32'h2000_0000, 32'h1000_0000}, packed G_N_SLV*G_W_ADDR; base address of slave i in slice i
G_SLV_MASK, {32'hF000_0000, 32'hF000_0000}, packed G_N_SLV*G_W_ADDR; compare mask of slave i
G_OUTS_DEPTH, 2, max outstanding transactions (power of 2, >=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
mst_cmd_valid/ready  in/out  1  master command handshake
mst_cmd_addr/read/wdata/wmask  in  G_W_ADDR/1/G_W_DATA/G_W_DATA/8  master command payload
mst_resp_valid/ready  out/in  1  master response handshake
mst_resp_rdata/err  out  G_W_DATA/1  master response payload
slv_cmd_valid/ready  out/in  G_N_SLV  per-slave command handshake
slv_cmd_addr/read/wdata/wmask  out  G_N_SLV*(each width)  per-slave payload, flattened; slice i = slave i
slv_resp_valid/ready  in/out  G_N_SLV  per-slave response handshake
slv_resp_rdata/err  in  G_N_SLV*G_W_DATA/G_N_SLV  per-slave response payload
dslv_cmd_*  out/in  as slave ports  default-slave command channel
dslv_resp_*  in/out  as slave ports  default-slave response channel

Behaviour:
- Reset:
  - Reset is synchronous, active-high, on clk. It clears the FIFO (wr_ptr, rd_ptr, count = 0).
  - All valid outputs and all ready outputs are 0 while the FIFO is empty/full as defined below. Payload outputs are don't-care.
- Decode (combinational):
  - Slave i matches when (mst_cmd_addr & MASK_i) == (BASE_i & MASK_i).
  - If several slaves match, the lowest index wins.
  - If none match, the target is the default port (index G_N_SLV).
- Command path (zero latency, combinational):
  - full = (count == G_OUTS_DEPTH).
  - The target's cmd_valid = mst_cmd_valid & ~full. All other ports' cmd_valid = 0.
  - mst_cmd_ready = target cmd_ready & ~full.
  - Payload is broadcast to all ports.
  - A command handshake pushes the target index into the FIFO.
- Response path (zero latency):
  - head = FIFO[rd_ptr]. Only the head port's resp_ready is driven, with mst_resp_ready. Every other resp_ready is 0.
  - mst_resp_valid = ~empty & head resp_valid. mst_resp_rdata/err are muxed from head.
  - A response handshake pops the FIFO.
  - A response from a non-head port is held off; this is legal ICB backpressure.
- Counter: count +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
  - Push while full cannot occur (ready low).
  - Pop while empty cannot occur (valid low).
- Pointers wrap modulo G_OUTS_DEPTH.
- Same-cycle cmd and resp on the same or a different port are independent.
- Reset mid-transaction drops all tracking. Slaves are reset by the same reset.
- No address/data registering; no timeout.

Optional Feature:
SRV_ICB_SPLT_ERR_CNT_EN
- Defined: adds output err_cnt [15:0].
  - Increments by 1 on every command handshake routed to the default port.
  - Saturates at 16'hFFFF. Reset clears it to 0.
- Undefined: no err_cnt port and no counter logic.

Decomposition:
- Package srv_icb_pkg holds:
  - the ICB field width constants (wmask width = G_W_DATA/8);
  - the target-index width function $clog2(G_N_SLV+1);
  - the localparam for the default-port index.
- One sub-module: srv_icb_splt_fifo. It is a synchronous FIFO of target indices with push/pop/full/empty/count and parameter G_OUTS_DEPTH.

Test Plan:
- Write to 0x1000_0004, slave0 ready=1 → slv_cmd_valid[0]=1 same cycle, count 0→1. slave0 resp err=0 → mst_resp_valid=1 and count →0.
- Read 0x2000_0010 then 0x1000_0000 back-to-back; slave1 holds its resp while slave0 asserts resp first → slv_resp_ready[0]=0 until slave1 resp handshakes. Master sees slave1 data first, then slave0 data.
- Read 0x3000_0000 (unmapped) → dslv_cmd_valid=1, no slv_cmd_valid. dslv resp err=1 → mst_resp_err=1. err_cnt=1 with SRV_ICB_SPLT_ERR_CNT_EN.
- G_OUTS_DEPTH=2: issue 3 commands with resp_ready=0 → third sees mst_cmd_ready=0 and all cmd_valid=0. Complete one response → third is accepted the next cycle. Check pointer wrap over 10 transactions.
- Assert reset for one cycle with count=2 outstanding → next cycle count=0, mst_resp_valid=0, and mst_cmd_ready follows target ready.
- Slave0 and slave1 windows overlapping with 0x1000_0000 in both → routed to slave0.
